// File: rtl/real_stim_gen_if.sv
// Stimulus generator bus: sequence control and programming inputs from the
// controlling side, stimulus level and status back from the generator.
interface real_stim_gen_if #(
  parameter int WIDTH = 18,
  parameter int CNT_W = 16
);
  logic                    start;
  logic                    abort;
  logic signed [WIDTH-1:0] v_init;
  logic signed [WIDTH-1:0] v_final;
  logic        [WIDTH-2:0] step;
  logic        [CNT_W-1:0] delay_cycles;
  logic        [CNT_W-1:0] hold_cycles;
  logic signed [WIDTH-1:0] v_out;
  logic                    busy;
  logic                    ramping;
  logic                    done;

  modport master (
    output start, abort, v_init, v_final, step, delay_cycles, hold_cycles,
    input  v_out, busy, ramping, done
  );

  modport slave (
    input  start, abort, v_init, v_final, step, delay_cycles, hold_cycles,
    output v_out, busy, ramping, done
  );
endinterface

// File: rtl/real_stim_gen.sv
// Programmable fixed-point stimulus source: initial level, delay, bounded
// ramp (or ideal step) to a final level, hold, then a one-cycle done pulse.
// The real value of v_out is v_out * 2**EXPONENT.
module real_stim_gen #(
  parameter int WIDTH    = 18,
  parameter int EXPONENT = -12,
  parameter int CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  real_stim_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DELAY, RAMP, HOLD} state_t;

  state_t                  state, state_nxt;
  logic        [CNT_W-1:0] cnt, cnt_nxt;
  logic signed [WIDTH-1:0] v_out_q, v_out_nxt;
  logic signed [WIDTH-1:0] v_final_q;
  logic        [WIDTH-2:0] step_q;
  logic        [CNT_W-1:0] delay_q, hold_q;
  logic                    busy_q, ramping_q, done_q;
  logic                    busy_nxt, ramping_nxt, done_nxt;
  logic                    accept;
  logic                    ramp_end;
  logic                    up;
  logic signed [WIDTH:0]   cur_ext, fin_ext, step_ext, nxt;
  logic        [31:0]      unused_exponent;

  // EXPONENT only documents the scaling of the words; it carries no logic.
  assign unused_exponent = EXPONENT;

  // A start is taken only from IDLE, and abort always wins over it.
  assign accept = (state == IDLE) && bus.start && !bus.abort;

  // Ramp arithmetic is one bit wider so that v_out +/- step can never wrap.
  assign cur_ext  = {v_out_q[WIDTH-1], v_out_q};
  assign fin_ext  = {v_final_q[WIDTH-1], v_final_q};
  assign step_ext = {2'b00, step_q};
  assign up       = fin_ext > cur_ext;
  assign nxt      = up ? (cur_ext + step_ext) : (cur_ext - step_ext);

  // State, counter, level and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      v_out_q   <= '0;
      busy_q    <= 1'b0;
      ramping_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      v_out_q   <= v_out_nxt;
      busy_q    <= busy_nxt;
      ramping_q <= ramping_nxt;
      done_q    <= done_nxt;
    end
  end

  // Sequence parameters are captured only when a start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_final_q <= '0;
      step_q    <= '0;
      delay_q   <= '0;
      hold_q    <= '0;
    end else if (accept) begin
      v_final_q <= bus.v_final;
      step_q    <= bus.step;
      delay_q   <= bus.delay_cycles;
      hold_q    <= bus.hold_cycles;
    end
  end

  // Next state, counter and level; abort overrides everything while busy.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    v_out_nxt = v_out_q;
    ramp_end  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          v_out_nxt = bus.v_init;
          cnt_nxt   = '0;
          state_nxt = (bus.delay_cycles != '0) ? DELAY : RAMP;
        end
      end
      DELAY: begin
        if (cnt == delay_q - CNT_W'(1)) begin
          state_nxt = RAMP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      RAMP: begin
        if ((v_out_q == v_final_q) || (step_q == '0)) begin
          ramp_end = 1'b1;
        end else if (up ? (nxt >= fin_ext) : (nxt <= fin_ext)) begin
          ramp_end = 1'b1;
        end else begin
          v_out_nxt = nxt[WIDTH-1:0];
        end
        if (ramp_end) begin
          v_out_nxt = v_final_q;
          cnt_nxt   = '0;
          state_nxt = (hold_q == '0) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (cnt == hold_q - CNT_W'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (bus.abort && (state != IDLE)) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      v_out_nxt = v_out_q;
    end
  end

  // Status flags for the coming cycle; done marks a normal, unaborted finish.
  always_comb begin
    busy_nxt    = (state_nxt != IDLE);
    ramping_nxt = (state_nxt == RAMP);
    done_nxt    = ((state == RAMP) || (state == HOLD)) && (state_nxt == IDLE) && !bus.abort;
  end

  assign bus.v_out   = v_out_q;
  assign bus.busy    = busy_q;
  assign bus.ramping = ramping_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_real_stim_gen.sv
// Directed testbench for real_stim_gen: ramp timing, clamping, ideal step,
// extremes, abort, ignored restart, mid-sequence reset, back-to-back start.
module tb_real_stim_gen;
  localparam int WIDTH = 18;
  localparam int CNT_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  real_stim_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  real_stim_gen #(.WIDTH(WIDTH), .EXPONENT(-12), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.v_init       = '0;
    bus.v_final      = '0;
    bus.step         = '0;
    bus.delay_cycles = '0;
    bus.hold_cycles  = '0;
  endtask

  task automatic load(input int vi, input int vf, input int st, input int dl, input int hd);
    bus.v_init       = WIDTH'(vi);
    bus.v_final      = WIDTH'(vf);
    bus.step         = (WIDTH-1)'(st);
    bus.delay_cycles = CNT_W'(dl);
    bus.hold_cycles  = CNT_W'(hd);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.v_out !== 0) begin n_fail++; $display("[TB] FAIL reset_v_out: got %0d expected 0", bus.v_out); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.ramping !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ramping: got %b expected 0", bus.ramping); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    cyc();
    cyc();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_ramp();
    int ev;
    logic eb, er, ed;
    load(0, 1000, 100, 3, 2);
    pulse_start();
    for (int i = 0; i < 17; i++) begin
      ev = (i <= 3) ? 0 : (i <= 13) ? (i - 3) * 100 : 1000;
      eb = (i <= 14);
      er = (i >= 3) && (i <= 12);
      ed = (i == 15);
      n_cmp++; if (bus.v_out !== ev) begin n_fail++; $display("[TB] FAIL ramp_v_out[%0d]: got %0d expected %0d", i, bus.v_out, ev); end
      n_cmp++; if (bus.busy !== eb) begin n_fail++; $display("[TB] FAIL ramp_busy[%0d]: got %b expected %b", i, bus.busy, eb); end
      n_cmp++; if (bus.ramping !== er) begin n_fail++; $display("[TB] FAIL ramp_ramping[%0d]: got %b expected %b", i, bus.ramping, er); end
      n_cmp++; if (bus.done !== ed) begin n_fail++; $display("[TB] FAIL ramp_done[%0d]: got %b expected %b", i, bus.done, ed); end
      cyc();
    end
  endtask

  task automatic test_nonint_ramp();
    int   ev [7] = '{500, 300, 100, -100, -260, -260, -260};
    logic ed [7] = '{0, 0, 0, 0, 0, 1, 0};
    logic eb [7] = '{1, 1, 1, 1, 1, 0, 0};
    load(500, -260, 200, 0, 1);
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      n_cmp++; if (bus.v_out !== ev[i]) begin n_fail++; $display("[TB] FAIL nonint_v_out[%0d]: got %0d expected %0d", i, bus.v_out, ev[i]); end
      n_cmp++; if (bus.done !== ed[i]) begin n_fail++; $display("[TB] FAIL nonint_done[%0d]: got %b expected %b", i, bus.done, ed[i]); end
      n_cmp++; if (bus.busy !== eb[i]) begin n_fail++; $display("[TB] FAIL nonint_busy[%0d]: got %b expected %b", i, bus.busy, eb[i]); end
      cyc();
    end
  endtask

  task automatic test_step_zero();
    int   ev [3] = '{-2048, 4095, 4095};
    logic ed [3] = '{0, 1, 0};
    logic eb [3] = '{1, 0, 0};
    logic er [3] = '{1, 0, 0};
    load(-2048, 4095, 0, 0, 0);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.v_out !== ev[i]) begin n_fail++; $display("[TB] FAIL step0_v_out[%0d]: got %0d expected %0d", i, bus.v_out, ev[i]); end
      n_cmp++; if (bus.done !== ed[i]) begin n_fail++; $display("[TB] FAIL step0_done[%0d]: got %b expected %b", i, bus.done, ed[i]); end
      n_cmp++; if (bus.busy !== eb[i]) begin n_fail++; $display("[TB] FAIL step0_busy[%0d]: got %b expected %b", i, bus.busy, eb[i]); end
      n_cmp++; if (bus.ramping !== er[i]) begin n_fail++; $display("[TB] FAIL step0_ramping[%0d]: got %b expected %b", i, bus.ramping, er[i]); end
      cyc();
    end
  endtask

  task automatic test_extremes();
    int   ev_up [4] = '{-131072, -1, 131070, 131071};
    int   ev_dn [4] = '{131071, 0, -131071, -131072};
    logic ed    [4] = '{0, 0, 0, 1};
    load(-131072, 131071, 131071, 0, 0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.v_out !== ev_up[i]) begin n_fail++; $display("[TB] FAIL ext_up_v_out[%0d]: got %0d expected %0d", i, bus.v_out, ev_up[i]); end
      n_cmp++; if (bus.done !== ed[i]) begin n_fail++; $display("[TB] FAIL ext_up_done[%0d]: got %b expected %b", i, bus.done, ed[i]); end
      if (i < 3) cyc();
    end
    load(131071, -131072, 131071, 0, 0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.v_out !== ev_dn[i]) begin n_fail++; $display("[TB] FAIL ext_dn_v_out[%0d]: got %0d expected %0d", i, bus.v_out, ev_dn[i]); end
      n_cmp++; if (bus.done !== ed[i]) begin n_fail++; $display("[TB] FAIL ext_dn_done[%0d]: got %b expected %b", i, bus.done, ed[i]); end
      cyc();
    end
  endtask

  task automatic test_abort();
    load(0, 1000, 100, 0, 0);
    pulse_start();
    for (int i = 0; i < 4; i++) cyc();
    n_cmp++; if (bus.v_out !== 400) begin n_fail++; $display("[TB] FAIL abort_pre_v_out: got %0d expected 400", bus.v_out); end
    n_cmp++; if (bus.ramping !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_pre_ramping: got %b expected 1", bus.ramping); end
    bus.abort  = 1'b1;
    bus.start  = 1'b1;
    bus.v_init = WIDTH'(7);
    cyc();
    n_cmp++; if (bus.v_out !== 400) begin n_fail++; $display("[TB] FAIL abort_v_out: got %0d expected 400", bus.v_out); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.ramping !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_ramping: got %b expected 0", bus.ramping); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_done: got %b expected 0", bus.done); end
    cyc();
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_start_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.v_out !== 400) begin n_fail++; $display("[TB] FAIL abort_start_v_out: got %0d expected 400", bus.v_out); end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_no_done[%0d]: got %b expected 0", i, bus.done); end
      n_cmp++; if (bus.v_out !== 400) begin n_fail++; $display("[TB] FAIL abort_hold_v_out[%0d]: got %0d expected 400", i, bus.v_out); end
    end
  endtask

  task automatic test_restart_busy();
    load(10, 50, 20, 1, 3);
    pulse_start();
    n_cmp++; if (bus.v_out !== 10) begin n_fail++; $display("[TB] FAIL rb_s0_v_out: got %0d expected 10", bus.v_out); end
    n_cmp++; if (bus.ramping !== 1'b0) begin n_fail++; $display("[TB] FAIL rb_s0_ramping: got %b expected 0", bus.ramping); end
    load(-999, -5000, 7, 0, 0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    n_cmp++; if (bus.v_out !== 10) begin n_fail++; $display("[TB] FAIL rb_s1_v_out: got %0d expected 10", bus.v_out); end
    n_cmp++; if (bus.ramping !== 1'b1) begin n_fail++; $display("[TB] FAIL rb_s1_ramping: got %b expected 1", bus.ramping); end
    cyc();
    n_cmp++; if (bus.v_out !== 30) begin n_fail++; $display("[TB] FAIL rb_s2_v_out: got %0d expected 30", bus.v_out); end
    cyc();
    n_cmp++; if (bus.v_out !== 50) begin n_fail++; $display("[TB] FAIL rb_s3_v_out: got %0d expected 50", bus.v_out); end
    n_cmp++; if (bus.ramping !== 1'b0) begin n_fail++; $display("[TB] FAIL rb_s3_ramping: got %b expected 0", bus.ramping); end
    cyc();
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rb_hold_busy: got %b expected 1", bus.busy); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.v_out !== 0) begin n_fail++; $display("[TB] FAIL rb_rst_v_out: got %0d expected 0", bus.v_out); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rb_rst_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL rb_rst_done: got %b expected 0", bus.done); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL rb_rst_no_done[%0d]: got %b expected 0", i, bus.done); end
    end
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rb_released_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.v_out !== 0) begin n_fail++; $display("[TB] FAIL rb_released_v_out: got %0d expected 0", bus.v_out); end
  endtask

  task automatic test_back_to_back();
    load(0, 300, 100, 0, 0);
    pulse_start();
    cyc();
    cyc();
    cyc();
    n_cmp++; if (bus.v_out !== 300) begin n_fail++; $display("[TB] FAIL b2b_first_v_out: got %0d expected 300", bus.v_out); end
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_first_done: got %b expected 1", bus.done); end
    load(-50, -50, 5, 0, 0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    n_cmp++; if (bus.v_out !== -50) begin n_fail++; $display("[TB] FAIL b2b_second_v_out: got %0d expected -50", bus.v_out); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_second_busy: got %b expected 1", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_second_done0: got %b expected 0", bus.done); end
    cyc();
    n_cmp++; if (bus.v_out !== -50) begin n_fail++; $display("[TB] FAIL b2b_equal_v_out: got %0d expected -50", bus.v_out); end
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_equal_done: got %b expected 1", bus.done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_equal_busy: got %b expected 0", bus.busy); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    idle_inputs();
    test_reset();
    test_ramp();
    test_nonint_ramp();
    test_step_zero();
    test_extremes();
    test_abort();
    test_restart_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
